// File: rtl/matrix_issue_queue.sv
// matrix_issue_queue: decode, buffer and in-order issue of matrix coprocessor instructions.
// Latency: an accepted legal word issues no earlier than the cycle after accept.
// Backpressure: instr_ready_o drops while the queue is full; the head waits for issue_ready_i and a clear scoreboard.
//
// Ports:
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   instr_valid_i/instr_ready_o       offload handshake; instr_i, rs1_i, rs2_i captured on accept
//   flush_i                           drop all queued, un-issued entries
//   illegal_o                         pulse one cycle after a non-matrix or out-of-range word is accepted
//   issue_valid_o/issue_ready_i       head issue; issue_* fields come combinationally from the head
//   retire_valid_i/retire_tmask_i     units release tiles
//   busy_o, empty_o                   scoreboard and queue status
module matrix_issue_queue #(
  parameter int DEPTH     = 4,
  parameter int NUM_TREGS = 8,
  parameter int XLEN      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 instr_valid_i,
  output logic                 instr_ready_o,
  input  logic [31:0]          instr_i,
  input  logic [XLEN-1:0]      rs1_i,
  input  logic [XLEN-1:0]      rs2_i,
  input  logic                 flush_i,
  output logic                 illegal_o,
  output logic                 issue_valid_o,
  input  logic                 issue_ready_i,
  output logic                 issue_unit_o,
  output logic [2:0]           issue_op_o,
  output logic [1:0]           issue_type_o,
  output logic [2:0]           issue_md_o,
  output logic [2:0]           issue_ms1_o,
  output logic [2:0]           issue_ms2_o,
  output logic [XLEN-1:0]      issue_rs1_o,
  output logic [XLEN-1:0]      issue_rs2_o,
  output logic [NUM_TREGS-1:0] issue_tmask_o,
  input  logic                 retire_valid_i,
  input  logic [NUM_TREGS-1:0] retire_tmask_i,
  output logic [NUM_TREGS-1:0] busy_o,
  output logic                 empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = 1;
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [6:0] OPC_MATRIX = 7'b0101011;

  localparam logic [2:0] OP_LD     = 3'd0;
  localparam logic [2:0] OP_ST     = 3'd1;
  localparam logic [2:0] OP_FMMACC = 3'd2;
  localparam logic [2:0] OP_IMAC   = 3'd3;
  localparam logic [2:0] OP_ZERO   = 3'd4;

  typedef struct packed {
    logic                 unit;
    logic [2:0]           op;
    logic [1:0]           typ;
    logic [2:0]           md;
    logic [2:0]           ms1;
    logic [2:0]           ms2;
    logic [XLEN-1:0]      rs1;
    logic [XLEN-1:0]      rs2;
    logic [NUM_TREGS-1:0] tmask;
  } entry_t;

  // One-hot tile mask for a 3-bit index; indices beyond NUM_TREGS give zero
  // and are rejected separately by tile_ok().
  function automatic logic [NUM_TREGS-1:0] tile_bit(input logic [2:0] idx);
    logic [NUM_TREGS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_TREGS; i++) begin
      if (idx == 3'(i)) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic tile_ok(input logic [2:0] idx);
    return ({1'b0, idx} < 4'(NUM_TREGS));
  endfunction

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  entry_t     dec_entry;
  logic       dec_legal;
  logic       fmt_ok;
  logic       use3;
  logic [4:0] f5;
  logic [2:0] f3;

  // Encoding overlaps are resolved in this order: the LD/ST form (marked by
  // [11:10] = 10) first, then ZERO, then the arithmetic forms. Among the
  // 00010 arithmetic words, funct3 separates FMMACC H/D (001/011) from
  // IMAC B (000). IMAC words must carry a funct3 equal to their element type.
  always_comb begin
    dec_entry     = '0;
    dec_entry.rs1 = rs1_i;
    dec_entry.rs2 = rs2_i;
    fmt_ok        = 1'b0;
    use3          = 1'b0;
    f5            = instr_i[31:27];
    f3            = instr_i[14:12];

    if (instr_i[6:0] == OPC_MATRIX) begin
      if ((f5[4:1] == 4'b0000) && (instr_i[11:10] == 2'b10)) begin
        fmt_ok         = !f3[2];
        dec_entry.unit = 1'b0;
        dec_entry.op   = f5[0] ? OP_ST : OP_LD;
        dec_entry.typ  = f3[1:0];
        dec_entry.md   = instr_i[9:7];
      end else if (instr_i[31:18] == 14'b11111000000000) begin
        fmt_ok         = 1'b1;
        dec_entry.unit = 1'b1;
        dec_entry.op   = OP_ZERO;
        dec_entry.typ  = f3[1:0];
        dec_entry.md   = instr_i[17:15];
      end else begin
        use3           = 1'b1;
        dec_entry.unit = 1'b1;
        dec_entry.md   = instr_i[17:15];
        dec_entry.ms1  = instr_i[20:18];
        dec_entry.ms2  = instr_i[23:21];
        if (f5 == 5'b00001) begin
          fmt_ok        = 1'b1;
          dec_entry.op  = OP_FMMACC;
          dec_entry.typ = 2'd2;
        end else if ((f5 == 5'b00010) && (f3 == 3'b001)) begin
          fmt_ok        = 1'b1;
          dec_entry.op  = OP_FMMACC;
          dec_entry.typ = 2'd1;
        end else if ((f5 == 5'b00010) && (f3 == 3'b011)) begin
          fmt_ok        = 1'b1;
          dec_entry.op  = OP_FMMACC;
          dec_entry.typ = 2'd3;
        end else if ((f5 == 5'b00010) && (f3 == 3'b000)) begin
          fmt_ok        = 1'b1;
          dec_entry.op  = OP_IMAC;
          dec_entry.typ = 2'd0;
        end else if ((f5 == 5'b11100) && (f3 == 3'b001)) begin
          fmt_ok        = 1'b1;
          dec_entry.op  = OP_IMAC;
          dec_entry.typ = 2'd1;
        end else if ((f5 == 5'b11110) && (f3 == 3'b010)) begin
          fmt_ok        = 1'b1;
          dec_entry.op  = OP_IMAC;
          dec_entry.typ = 2'd2;
        end
      end
    end

    dec_entry.tmask = tile_bit(dec_entry.md);
    if (use3) begin
      dec_entry.tmask = dec_entry.tmask | tile_bit(dec_entry.ms1) | tile_bit(dec_entry.ms2);
    end

    dec_legal = fmt_ok && tile_ok(dec_entry.md) &&
                (!use3 || (tile_ok(dec_entry.ms1) && tile_ok(dec_entry.ms2)));
  end

  // ---------------------------------------------------------------------------
  // Queue storage and pointers
  // ---------------------------------------------------------------------------
  entry_t               mem_q [DEPTH];
  logic [PW-1:0]        head_q, tail_q;
  logic [CW-1:0]        count_q;
  logic [NUM_TREGS-1:0] busy_q;
  logic                 illegal_q;

  entry_t               head;
  logic                 full;
  logic                 empty;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic [NUM_TREGS-1:0] busy_d;

  assign head   = mem_q[head_q];
  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  assign accept = instr_valid_i && instr_ready_o;
  assign push   = accept && dec_legal && !flush_i;
  assign pop    = issue_valid_o;

  // Ready ignores a same-cycle pop so a full queue never passes through.
  assign instr_ready_o = !full;

  // Hazard check uses the registered scoreboard only; a retire is seen next cycle.
  assign issue_valid_o = !empty && issue_ready_i && ((busy_q & head.tmask) == '0);

  // Set after clear so a tile issued and retired in the same cycle stays busy.
  assign busy_d = (busy_q & ~(retire_valid_i ? retire_tmask_i : '0)) |
                  (pop ? head.tmask : '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[tail_q] <= dec_entry;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      busy_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      illegal_q <= accept && !dec_legal;
      if (flush_i) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (pop)  head_q <= head_q + PTR_ONE;
        if (push) tail_q <= tail_q + PTR_ONE;
        case ({push, pop})
          2'b10:   count_q <= count_q + CNT_ONE;
          2'b01:   count_q <= count_q - CNT_ONE;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: issue fields follow the head slot, so they stay put while stalled.
  // ---------------------------------------------------------------------------
  assign issue_unit_o  = head.unit;
  assign issue_op_o    = head.op;
  assign issue_type_o  = head.typ;
  assign issue_md_o    = head.md;
  assign issue_ms1_o   = head.ms1;
  assign issue_ms2_o   = head.ms2;
  assign issue_rs1_o   = head.rs1;
  assign issue_rs2_o   = head.rs2;
  assign issue_tmask_o = head.tmask;
  assign illegal_o     = illegal_q;
  assign busy_o        = busy_q;
  assign empty_o       = empty;

endmodule

// File: tb/tb_matrix_issue_queue.sv
// Bench for matrix_issue_queue: directed scenarios plus a randomized run
// checked against a transaction-level model (queue of expected ops + tile set).
module tb_matrix_issue_queue;
  localparam int DEPTH = 4;
  localparam int NT    = 8;
  localparam int XLEN  = 32;

  logic            clk, rst_n;
  logic            instr_valid, instr_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] rs1, rs2;
  logic            flush, illegal;
  logic            issue_valid, issue_ready, issue_unit;
  logic [2:0]      issue_op;
  logic [1:0]      issue_type;
  logic [2:0]      issue_md, issue_ms1, issue_ms2;
  logic [XLEN-1:0] issue_rs1, issue_rs2;
  logic [NT-1:0]   issue_tmask;
  logic            retire_valid;
  logic [NT-1:0]   retire_tmask;
  logic [NT-1:0]   busy;
  logic            empty;

  matrix_issue_queue #(.DEPTH(DEPTH), .NUM_TREGS(NT), .XLEN(XLEN)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_valid_i(instr_valid), .instr_ready_o(instr_ready), .instr_i(instr),
    .rs1_i(rs1), .rs2_i(rs2), .flush_i(flush), .illegal_o(illegal),
    .issue_valid_o(issue_valid), .issue_ready_i(issue_ready), .issue_unit_o(issue_unit),
    .issue_op_o(issue_op), .issue_type_o(issue_type), .issue_md_o(issue_md),
    .issue_ms1_o(issue_ms1), .issue_ms2_o(issue_ms2), .issue_rs1_o(issue_rs1),
    .issue_rs2_o(issue_rs2), .issue_tmask_o(issue_tmask),
    .retire_valid_i(retire_valid), .retire_tmask_i(retire_tmask),
    .busy_o(busy), .empty_o(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic        unit;
    logic [2:0]  op;
    logic [1:0]  ty;
    logic [2:0]  md, ms1, ms2;
    logic [31:0] rs1, rs2;
    logic [7:0]  tm;
  } exp_t;

  // Builds an instruction word from a mnemonic and its operands, and the op
  // the issue port should show for it.
  // kind: 0 LD, 1 ST, 2 FMMACC.S, 3 FMMACC.H, 4 FMMACC.D, 5 MMAQA, 6 MMADA, 7 MMASA, 8 ZERO
  task automatic encode(input int kind, input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] c, input logic [1:0] ty,
                        output logic [31:0] w, output exp_t e);
    logic [4:0] f5;
    logic [2:0] f3;
    e = '0;
    e.md = a;
    e.unit = 1'b1;
    e.tm = 8'(1) << a;
    f5 = 5'b0;
    f3 = 3'b0;
    case (kind)
      0: begin w = {5'b00000, 12'b0, 1'b0, ty, 2'b10, a, 7'h2B}; e.unit = 1'b0; e.op = 3'd0; e.ty = ty; end
      1: begin w = {5'b00001, 12'b0, 1'b0, ty, 2'b10, a, 7'h2B}; e.unit = 1'b0; e.op = 3'd1; e.ty = ty; end
      8: begin w = {14'b11111000000000, a, 1'b0, ty, 5'b0, 7'h2B}; e.op = 3'd4; e.ty = ty; end
      default: begin
        case (kind)
          2: begin f5 = 5'b00001; f3 = 3'b010; e.op = 3'd2; e.ty = 2'd2; end
          3: begin f5 = 5'b00010; f3 = 3'b001; e.op = 3'd2; e.ty = 2'd1; end
          4: begin f5 = 5'b00010; f3 = 3'b011; e.op = 3'd2; e.ty = 2'd3; end
          5: begin f5 = 5'b00010; f3 = 3'b000; e.op = 3'd3; e.ty = 2'd0; end
          6: begin f5 = 5'b11100; f3 = 3'b001; e.op = 3'd3; e.ty = 2'd1; end
          default: begin f5 = 5'b11110; f3 = 3'b010; e.op = 3'd3; e.ty = 2'd2; end
        endcase
        w = {f5, 3'b0, c, b, a, f3, 5'b0, 7'h2B};
        e.ms1 = b;
        e.ms2 = c;
        e.tm = e.tm | (8'(1) << b) | (8'(1) << c);
      end
    endcase
  endtask

  task automatic idle();
    instr_valid = 1'b0; instr = 32'h0; rs1 = '0; rs2 = '0;
    flush = 1'b0; retire_valid = 1'b0; retire_tmask = '0;
  endtask

  task automatic apply_reset();
    idle();
    issue_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    issue_ready = 1'b1;
    #1;
    n_vec++; if (empty !== 1'b1)       begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_vec++; if (busy !== 8'h00)       begin n_err++; $display("FAIL reset_busy: got %h want 00", busy); end
    n_vec++; if (illegal !== 1'b0)     begin n_err++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    n_vec++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL reset_issue_valid: got %b want 0", issue_valid); end
    n_vec++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
  endtask

  task automatic test_ld_issue();
    logic [31:0] w; exp_t e;
    @(negedge clk);
    encode(0, 3'd2, 3'd0, 3'd0, 2'd2, w, e);
    instr = w; rs1 = 32'h1000; rs2 = 32'h40; instr_valid = 1'b1; issue_ready = 1'b1;
    #1;
    n_vec++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL ld_no_passthru: got %b want 0", issue_valid); end
    @(negedge clk); idle(); #1;
    n_vec++; if (issue_valid !== 1'b1)   begin n_err++; $display("FAIL ld_valid: got %b want 1", issue_valid); end
    n_vec++; if (issue_op !== 3'd0)      begin n_err++; $display("FAIL ld_op: got %0d want 0", issue_op); end
    n_vec++; if (issue_unit !== 1'b0)    begin n_err++; $display("FAIL ld_unit: got %b want 0", issue_unit); end
    n_vec++; if (issue_md !== 3'd2)      begin n_err++; $display("FAIL ld_md: got %0d want 2", issue_md); end
    n_vec++; if (issue_tmask !== 8'h04)  begin n_err++; $display("FAIL ld_tmask: got %h want 04", issue_tmask); end
    n_vec++; if (issue_rs1 !== 32'h1000) begin n_err++; $display("FAIL ld_rs1: got %h want 1000", issue_rs1); end
    n_vec++; if (issue_rs2 !== 32'h40)   begin n_err++; $display("FAIL ld_rs2: got %h want 40", issue_rs2); end
    n_vec++; if (issue_type !== 2'd2)    begin n_err++; $display("FAIL ld_type: got %0d want 2", issue_type); end
    @(negedge clk); #1;
    n_vec++; if (busy !== 8'h04) begin n_err++; $display("FAIL ld_busy: got %h want 04", busy); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL ld_empty: got %b want 1", empty); end
  endtask

  task automatic test_hazard();
    logic [31:0] w; exp_t e;
    @(negedge clk);
    encode(2, 3'd0, 3'd1, 3'd2, 2'd0, w, e);
    instr = w; instr_valid = 1'b1;
    @(negedge clk); idle(); #1;
    n_vec++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL hz_held: got %b want 0", issue_valid); end
    @(negedge clk); retire_valid = 1'b1; retire_tmask = 8'h04; #1;
    n_vec++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL hz_no_bypass: got %b want 0", issue_valid); end
    @(negedge clk); idle(); #1;
    n_vec++; if (issue_valid !== 1'b1)  begin n_err++; $display("FAIL hz_issue: got %b want 1", issue_valid); end
    n_vec++; if (issue_tmask !== 8'h07) begin n_err++; $display("FAIL hz_tmask: got %h want 07", issue_tmask); end
    n_vec++; if (issue_op !== 3'd2)     begin n_err++; $display("FAIL hz_op: got %0d want 2", issue_op); end
    n_vec++; if (issue_unit !== 1'b1)   begin n_err++; $display("FAIL hz_unit: got %b want 1", issue_unit); end
    n_vec++; if (issue_ms1 !== 3'd1 || issue_ms2 !== 3'd2)
      begin n_err++; $display("FAIL hz_ms: got %0d/%0d want 1/2", issue_ms1, issue_ms2); end
    @(negedge clk); #1;
    n_vec++; if (busy !== 8'h07) begin n_err++; $display("FAIL hz_busy: got %h want 07", busy); end
    retire_valid = 1'b1; retire_tmask = 8'h07;
    @(negedge clk); idle(); #1;
    n_vec++; if (busy !== 8'h00) begin n_err++; $display("FAIL hz_released: got %h want 00", busy); end
  endtask

  task automatic test_fill();
    logic [31:0] w; exp_t e;
    issue_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      encode(8, 3'(i), 3'd0, 3'd0, 2'd0, w, e);
      instr = w; instr_valid = 1'b1; #1;
      n_vec++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready%0d: got %b want 1", i, instr_ready); end
    end
    @(negedge clk); idle(); #1;
    n_vec++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL fill_full: got %b want 0", instr_ready); end
    // Release while offering a fifth word: the pop must not open the door this cycle.
    @(negedge clk);
    encode(8, 3'd7, 3'd0, 3'd0, 2'd0, w, e);
    instr = w; instr_valid = 1'b1; issue_ready = 1'b1; #1;
    n_vec++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL fill_no_pass: got %b want 0", instr_ready); end
    n_vec++; if (issue_valid !== 1'b1 || issue_md !== 3'd0)
      begin n_err++; $display("FAIL fill_issue0: got v=%b md=%0d want v=1 md=0", issue_valid, issue_md); end
    for (int i = 1; i < DEPTH; i++) begin
      @(negedge clk); idle(); #1;
      n_vec++; if (issue_valid !== 1'b1 || issue_md !== 3'(i))
        begin n_err++; $display("FAIL fill_issue%0d: got v=%b md=%0d want v=1 md=%0d", i, issue_valid, issue_md, i); end
    end
    @(negedge clk); #1;
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL fill_empty: got %b want 1", empty); end
    n_vec++; if (busy !== 8'h0F) begin n_err++; $display("FAIL fill_busy: got %h want 0f", busy); end
    retire_valid = 1'b1; retire_tmask = 8'h0F;
    @(negedge clk); idle();
  endtask

  task automatic test_illegal();
    @(negedge clk);
    instr = 32'h00000013; instr_valid = 1'b1; issue_ready = 1'b1; #1;
    n_vec++; if (illegal !== 1'b0) begin n_err++; $display("FAIL ill_early: got %b want 0", illegal); end
    @(negedge clk); idle(); #1;
    n_vec++; if (illegal !== 1'b1) begin n_err++; $display("FAIL ill_pulse: got %b want 1", illegal); end
    n_vec++; if (empty !== 1'b1)   begin n_err++; $display("FAIL ill_empty: got %b want 1", empty); end
    @(negedge clk); #1;
    n_vec++; if (illegal !== 1'b0) begin n_err++; $display("FAIL ill_width: got %b want 0", illegal); end
  endtask

  task automatic test_set_wins();
    logic [31:0] w; exp_t e;
    @(negedge clk);
    encode(8, 3'd3, 3'd0, 3'd0, 2'd0, w, e);
    instr = w; instr_valid = 1'b1; issue_ready = 1'b1;
    @(negedge clk); idle(); retire_valid = 1'b1; retire_tmask = 8'h08; #1;
    n_vec++; if (issue_valid !== 1'b1 || issue_md !== 3'd3)
      begin n_err++; $display("FAIL sw_issue: got v=%b md=%0d want v=1 md=3", issue_valid, issue_md); end
    @(negedge clk); idle(); #1;
    n_vec++; if (busy !== 8'h08) begin n_err++; $display("FAIL sw_busy: got %h want 08", busy); end
  endtask

  task automatic test_flush();
    logic [31:0] w; exp_t e;
    issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      encode(8, 3'(i), 3'd0, 3'd0, 2'd0, w, e);
      instr = w; instr_valid = 1'b1;
    end
    @(negedge clk);
    encode(8, 3'd4, 3'd0, 3'd0, 2'd0, w, e);
    instr = w; instr_valid = 1'b1; flush = 1'b1; #1;
    n_vec++; if (empty !== 1'b0) begin n_err++; $display("FAIL fl_before: got %b want 0", empty); end
    @(negedge clk); idle(); issue_ready = 1'b1; #1;
    n_vec++; if (empty !== 1'b1)       begin n_err++; $display("FAIL fl_empty: got %b want 1", empty); end
    n_vec++; if (busy !== 8'h08)       begin n_err++; $display("FAIL fl_busy: got %h want 08", busy); end
    n_vec++; if (issue_valid !== 1'b0) begin n_err++; $display("FAIL fl_dropped: got %b want 0", issue_valid); end
    retire_valid = 1'b1; retire_tmask = 8'h08;
    @(negedge clk); idle(); #1;
    n_vec++; if (busy !== 8'h00) begin n_err++; $display("FAIL fl_retire: got %h want 00", busy); end
  endtask

  task automatic test_random();
    exp_t        q[$];
    logic [7:0]  busy_m;
    logic        ill_m, fire, legal, acc;
    logic [31:0] w;
    exp_t        e, h;
    logic [2:0]  a, b, c;
    apply_reset();
    busy_m = '0; ill_m = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      idle();
      a = 3'($urandom_range(0, 7)); b = 3'($urandom_range(0, 7)); c = 3'($urandom_range(0, 7));
      encode(int'($urandom_range(0, 8)), a, b, c, 2'($urandom_range(0, 3)), w, e);
      legal = 1'b1;
      if ($urandom_range(0, 4) == 0) begin
        legal = 1'b0;
        case ($urandom_range(0, 3))
          0: w = w ^ 32'h4;
          1: w = {5'b00000, 12'b0, 3'b000, 2'b01, a, 7'h2B};
          2: w = {5'b11100, 3'b0, c, b, a, 3'b010, 5'b0, 7'h2B};
          default: w = 32'h00000013;
        endcase
      end
      e.rs1 = $urandom; e.rs2 = $urandom;
      instr = w; rs1 = e.rs1; rs2 = e.rs2;
      instr_valid  = ($urandom_range(0, 9) < 6);
      issue_ready  = ($urandom_range(0, 9) < 7);
      retire_valid = ($urandom_range(0, 9) < 3);
      retire_tmask = 8'($urandom) & busy_m;
      flush        = ($urandom_range(0, 99) < 3);
      #1;
      fire = (q.size() != 0) && issue_ready && ((busy_m & q[0].tm) == 8'h00);
      n_vec++; if (instr_ready !== (q.size() < DEPTH))
        begin n_err++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, instr_ready, q.size() < DEPTH); end
      n_vec++; if (empty !== (q.size() == 0))
        begin n_err++; $display("FAIL rnd_empty c%0d: got %b want %b", cyc, empty, q.size() == 0); end
      n_vec++; if (busy !== busy_m) begin n_err++; $display("FAIL rnd_busy c%0d: got %h want %h", cyc, busy, busy_m); end
      n_vec++; if (illegal !== ill_m) begin n_err++; $display("FAIL rnd_illegal c%0d: got %b want %b", cyc, illegal, ill_m); end
      n_vec++; if (issue_valid !== fire)
        begin n_err++; $display("FAIL rnd_valid c%0d: got %b want %b", cyc, issue_valid, fire); end
      if (fire) begin
        h = q[0];
        n_vec++; if (issue_op !== h.op || issue_unit !== h.unit || issue_md !== h.md)
          begin n_err++; $display("FAIL rnd_op c%0d: got op%0d u%b md%0d want op%0d u%b md%0d",
                                  cyc, issue_op, issue_unit, issue_md, h.op, h.unit, h.md); end
        n_vec++; if (issue_tmask !== h.tm)
          begin n_err++; $display("FAIL rnd_tmask c%0d: got %h want %h", cyc, issue_tmask, h.tm); end
        n_vec++; if (issue_rs1 !== h.rs1 || issue_rs2 !== h.rs2)
          begin n_err++; $display("FAIL rnd_rs c%0d: got %h/%h want %h/%h", cyc, issue_rs1, issue_rs2, h.rs1, h.rs2); end
        if (h.op != 3'd4) begin
          n_vec++; if (issue_type !== h.ty)
            begin n_err++; $display("FAIL rnd_type c%0d: got %0d want %0d", cyc, issue_type, h.ty); end
        end
        if (h.op == 3'd2 || h.op == 3'd3) begin
          n_vec++; if (issue_ms1 !== h.ms1 || issue_ms2 !== h.ms2)
            begin n_err++; $display("FAIL rnd_ms c%0d: got %0d/%0d want %0d/%0d", cyc, issue_ms1, issue_ms2, h.ms1, h.ms2); end
        end
      end
      // Advance the model by one clock.
      acc = instr_valid && (q.size() < DEPTH);
      busy_m = busy_m & ~(retire_valid ? retire_tmask : 8'h00);
      if (fire) begin
        busy_m = busy_m | q[0].tm;
        void'(q.pop_front());
      end
      if (flush) q.delete();
      else if (acc && legal) q.push_back(e);
      ill_m = acc && !legal;
    end
    @(negedge clk); idle();
  endtask

  initial begin
    test_reset();
    test_ld_issue();
    test_hazard();
    test_fill();
    test_illegal();
    test_set_wins();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/matrix_issue_queue.md
Name: matrix_issue_queue

Overview:
- In-order decode, buffer and issue stage for matrix coprocessor instructions (custom opcode 7'b0101011), sitting between the core's offload interface and the matrix LSU/MAC units.
- Decodes each accepted instruction into an operation class, element type and tile-register operands, then stores it in a DEPTH-entry FIFO.
- Issues from the head only when a per-tile scoreboard shows no conflict. Units retire tiles back via a mask.
- Generalises the fixed encoding tables with parametrised queue depth, tile-register count and operand width.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..16.
- NUM_TREGS, 8, tile registers tracked by the scoreboard; 2..8 (tile fields are 3 bits).
- XLEN, 32, width of scalar operands rs1/rs2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- instr_valid_i  in  1  offload instruction valid
- instr_ready_o  out  1  offload ready
- instr_i  in  32  instruction word
- rs1_i  in  XLEN  scalar operand 1 (base address)
- rs2_i  in  XLEN  scalar operand 2 (stride)
- flush_i  in  1  discard all queued, un-issued entries
- illegal_o  out  1  one-cycle pulse: accepted word was not a matrix instruction
- issue_valid_o  out  1  head entry issued this cycle
- issue_ready_i  in  1  target unit can accept
- issue_unit_o  out  1  0 = LSU, 1 = MAC
- issue_op_o  out  3  0 LD, 1 ST, 2 FMMACC, 3 IMAC, 4 ZERO
- issue_type_o  out  2  0 = 8-bit, 1 = 16-bit, 2 = 32-bit, 3 = 64-bit
- issue_md_o, issue_ms1_o, issue_ms2_o  out  3 each  tile indices
- issue_rs1_o, issue_rs2_o  out  XLEN each  latched scalars
- issue_tmask_o  out  NUM_TREGS  tiles referenced by the issued op
- retire_valid_i  in  1  a unit finished an op
- retire_tmask_i  in  NUM_TREGS  tiles to release
- busy_o  out  NUM_TREGS  scoreboard state
- empty_o  out  1  queue empty

Behaviour:
- Reset: queue empty, scoreboard 0, illegal_o = 0, issue_valid_o = 0, empty_o = 1.
- instr_ready_o = !full. This holds for illegal words too.
- Handshake: an accept is instr_valid_i & instr_ready_o. On accept, the word is decoded combinationally.
- Decode, common: instr[6:0] must equal 7'b0101011.
- Arithmetic fields: md = [17:15], ms1 = [20:18], ms2 = [23:21].
- FMMACC: [31:27] = 00001 → type S, or 00010 → type H/D by [14:12] (001 H, 011 D).
- IMAC: [31:27] = 00010 → type B (MMAQA), 11100 → H (MMADA), 11110 → W (MMASA); [14:12] gives the type.
- ZERO: [31:18] = 14'b11111000000000.
- LD/ST: [31:27] = 00000/00001, [11:10] = 10, md/ms3 = [9:7], type = [14:12].
- Any other word → no enqueue; illegal_o = 1 on the following cycle.
- Referenced tiles:
  - LD, ZERO: {md}.
  - ST: {ms3}.
  - FMMACC, IMAC: {md, ms1, ms2}.
  - Any index >= NUM_TREGS → illegal.
- Issue rule: head entry is issued when non-empty & issue_ready_i & ((busy_q & tmask) == 0).
  - issue_valid_o and all issue_* outputs are combinational from the head.
  - issue_* outputs hold their value while issue_valid_o = 0.
  - Strictly in order: a blocked head stalls every entry behind it.
- Scoreboard: busy_d = (busy_q & ~(retire_valid_i ? retire_tmask_i : 0)) | (issue fire ? tmask : 0). When a bit is both set and cleared in one cycle, set wins.
  - The hazard check uses the registered busy_q, with no bypass. A retire releases the head no earlier than the next cycle.
- Latency: an accepted legal word into an empty queue with free tiles issues on the next cycle (1-cycle minimum).
- Full with simultaneous issue: the pop happens this cycle but instr_ready_o stays 0 that cycle (no same-cycle pass-through).
- Wrap-around: head/tail pointers are log2(DEPTH) bits and wrap naturally; a count register distinguishes full from empty.
- flush_i:
  - Empties the queue the next cycle; any accept in the same cycle is dropped.
  - A same-cycle issue still completes.
  - The scoreboard is not cleared; outstanding ops still retire.
- Reset mid-operation clears everything asynchronously; pending retires are lost by design.

Test Plan:
- Reset, then LD tile 2 (type W, rs1 = 0x1000, rs2 = 0x40), issue_ready_i = 1 → issue next cycle: op 0, unit 0, md = 2, tmask = 0x04, rs1 = 0x1000; busy_o = 0x04.
- With busy_o = 0x04, send FMMACC_S md = 0, ms1 = 1, ms2 = 2 → held; retire mask 0x04 at cycle t → issue at t+1 with tmask = 0x07.
- issue_ready_i = 0, push DEPTH = 4 legal ZEROs → instr_ready_o = 0 after the 4th accept; release → 4 issues in order, then empty_o = 1.
- Accept 0x00000013 → illegal_o pulses for exactly 1 cycle; no enqueue; empty_o stays 1.
- Same cycle: retire tile 3 and issue ZERO md = 3 → busy_o[3] = 1 afterwards.
- 3 entries queued, assert flush_i → empty_o = 1 next cycle; busy_o unchanged.
